// File: rtl/uart_axil_writer.sv
// UART RX FIFO to AXI4-Lite writer.
// Packs FIFO bytes little-endian into words and writes them to a wrapping window.
module uart_axil_writer #(
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter int unsigned           AXI_DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int unsigned           REGION_BYTES   = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       fifo_data,
  input  logic                        fifo_empty,
  output logic                        fifo_ren,
  input  logic                        flush,
  output logic [ADDR_WIDTH-1:0]       m_awaddr,
  output logic                        m_awvalid,
  input  logic                        m_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_wstrb,
  output logic                        m_wvalid,
  input  logic                        m_wready,
  input  logic [1:0]                  m_bresp,
  input  logic                        m_bvalid,
  output logic                        m_bready,
  output logic                        busy,
  output logic [31:0]                 words_written,
  output logic                        err
);

  localparam int unsigned BPW = AXI_DATA_WIDTH / 8;
  localparam int unsigned CW  = $clog2(BPW + 1);

  localparam logic [CW-1:0]         FULL     = CW'(BPW);
  localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(BPW);
  localparam logic [ADDR_WIDTH-1:0] END_ADDR =
    BASE_ADDR + ADDR_WIDTH'(REGION_BYTES);

  if (DATA_WIDTH != 8) begin : g_dw_chk
    $error("uart_axil_writer: DATA_WIDTH must be 8");
  end

  if (AXI_DATA_WIDTH != 32 && AXI_DATA_WIDTH != 64) begin : g_aw_chk
    $error("uart_axil_writer: AXI_DATA_WIDTH must be 32 or 64");
  end

  typedef enum logic [2:0] {
    IDLE,
    POP,
    CAPT,
    ISSUE,
    RESP
  } state_e;

  state_e                    state_q;
  logic [CW-1:0]             cnt_q;
  logic [AXI_DATA_WIDTH-1:0] wbuf_q;
  logic [BPW-1:0]            strb_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic                      awvalid_q;
  logic                      wvalid_q;
  logic                      aw_done_q;
  logic                      w_done_q;
  logic                      bready_q;
  logic [31:0]               words_q;
  logic                      err_q;

  logic [AXI_DATA_WIDTH-1:0] wbuf_d;
  logic [BPW-1:0]            strb_d;
  logic [ADDR_WIDTH-1:0]     addr_inc;
  logic [ADDR_WIDTH-1:0]     addr_d;
  logic                      go_issue;
  logic                      aw_hs;
  logic                      w_hs;
  logic                      both_done;

  // Lane insertion for the byte being captured; buffers are zero between words.
  assign wbuf_d = wbuf_q |
    ({{(AXI_DATA_WIDTH-DATA_WIDTH){1'b0}}, fifo_data} << {cnt_q, 3'b000});
  assign strb_d = strb_q | (BPW'(1) << cnt_q);

  // Next write address, folding back to the window base at its end.
  assign addr_inc = addr_q + STEP;
  assign addr_d   = (addr_inc == END_ADDR) ? BASE_ADDR : addr_inc;

  // A full word wins; FIFO bytes drain before a partial flush is honoured.
  assign go_issue = (cnt_q == FULL) ||
                    (fifo_empty && flush && cnt_q != '0);

  assign aw_hs     = awvalid_q && m_awready;
  assign w_hs      = wvalid_q && m_wready;
  assign both_done = (aw_done_q || aw_hs) && (w_done_q || w_hs);

  // Sequencer: byte gathering, AW/W issue and B acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wbuf_q    <= '0;
      strb_q    <= '0;
      addr_q    <= BASE_ADDR;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bready_q  <= 1'b0;
      words_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (go_issue) begin
            state_q   <= ISSUE;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end else if (!fifo_empty) begin
            state_q <= POP;
          end
        end
        POP: begin
          state_q <= CAPT;
        end
        CAPT: begin
          wbuf_q  <= wbuf_d;
          strb_q  <= strb_d;
          cnt_q   <= cnt_q + CW'(1);
          state_q <= IDLE;
        end
        ISSUE: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (both_done) begin
            state_q  <= RESP;
            bready_q <= 1'b1;
          end
        end
        RESP: begin
          if (m_bvalid) begin
            if (m_bresp != 2'b00) begin
              err_q <= 1'b1;
            end
            words_q   <= words_q + 32'd1;
            addr_q    <= addr_d;
            wbuf_q    <= '0;
            strb_q    <= '0;
            cnt_q     <= '0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign fifo_ren      = (state_q == POP);
  assign m_awaddr      = addr_q;
  assign m_awvalid     = awvalid_q;
  assign m_wdata       = wbuf_q;
  assign m_wstrb       = strb_q;
  assign m_wvalid      = wvalid_q;
  assign m_bready      = bready_q;
  assign words_written = words_q;
  assign err           = err_q;
  assign busy          = (state_q != IDLE) || (cnt_q != '0);

endmodule
